// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: generic pipeline stage register with a valid/ready handshake,
// a 2-entry skid buffer and a synchronous flush. Callers concatenate their
// stage fields into in_data.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   upstream word present
//   in_ready   stage can accept a word (registered)
//   in_data    upstream payload [DATA_W]
//   out_valid  stage holds a word for downstream (registered)
//   out_ready  downstream accepts the word
//   out_data   payload of the oldest held word (registered) [DATA_W]
//   flush      kill all held words
//   occupancy  number of words held, 0..2
//   stall_cnt  saturating count of out_valid & !out_ready cycles [CNT_W]
//              (present only when PIPE_STAT_EN is defined)
//
// Build option: define PIPE_STAT_EN to add the stall counter.

module pipe_skid_reg #(
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] RST_DATA = '0,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy
`ifdef PIPE_STAT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  localparam int unsigned OCC_W = 2;

  // Parameter sanity checks at elaboration
  if (DATA_W == 0) begin : g_data_w_check
    $error("pipe_skid_reg: DATA_W must be at least 1");
  end
  if (CNT_W == 0) begin : g_cnt_w_check
    $error("pipe_skid_reg: CNT_W must be at least 1");
  end

  // State encoding equals the number of held words
  typedef enum logic [OCC_W-1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] main_nxt;
  logic [DATA_W-1:0] skid_nxt;
  logic              acc;
  logic              pop;

  assign occupancy = OCC_W'(state);

  // Next-state and datapath selection; flush overrides any handshake
  always_comb begin
    state_nxt = state;
    main_nxt  = out_data;
    skid_nxt  = skid_data;
    acc       = in_valid & in_ready;
    pop       = out_valid & out_ready;
    if (flush) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (acc) begin
            main_nxt  = in_data;
            state_nxt = S_ONE;
          end
        end
        S_ONE: begin
          if (acc && pop) begin
            main_nxt = in_data;
          end else if (acc) begin
            skid_nxt  = in_data;
            state_nxt = S_TWO;
          end else if (pop) begin
            state_nxt = S_EMPTY;
          end
        end
        S_TWO: begin
          // in_ready is low here, so only a pop can happen
          if (pop) begin
            main_nxt  = skid_data;
            state_nxt = S_ONE;
          end
        end
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  // State, data and handshake registers; handshake flags follow next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= RST_DATA;
      skid_data <= RST_DATA;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != S_EMPTY);
      in_ready  <= (state_nxt != S_TWO);
      out_data  <= main_nxt;
      skid_data <= skid_nxt;
    end
  end

`ifdef PIPE_STAT_EN
  // Saturating stall counter; only reset clears it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
